// File: rtl/vga_timing_pkg.sv
// Shared VGA timing definitions: 640x480@60 defaults, the per-axis phase type
// and the axis-total helper.
package vga_timing_pkg;

   localparam int unsigned DEF_H_ACTIVE = 640;
   localparam int unsigned DEF_H_FP     = 16;
   localparam int unsigned DEF_H_SYNC   = 96;
   localparam int unsigned DEF_H_BP     = 48;
   localparam int unsigned DEF_V_ACTIVE = 480;
   localparam int unsigned DEF_V_FP     = 10;
   localparam int unsigned DEF_V_SYNC   = 2;
   localparam int unsigned DEF_V_BP     = 33;
   localparam logic        DEF_SYNC_POL = 1'b0;

   typedef enum logic [1:0] {
      PH_ACTIVE = 2'd0,
      PH_FP     = 2'd1,
      PH_SYNC   = 2'd2,
      PH_BP     = 2'd3
   } phase_t;

   function automatic int unsigned axis_total(input int unsigned active, input int unsigned fp,
                                              input int unsigned sync, input int unsigned bp);
      return active + fp + sync + bp;
   endfunction

endpackage

// File: rtl/vga_sync_gen_if.sv
// Timing bundle between the sync generator (master) and the pixel-colour logic (slave).
interface vga_sync_gen_if;
   logic       ce;
   logic [9:0] hpos;
   logic [9:0] vpos;
   logic       hsync;
   logic       vsync;
   logic       display_on;
   logic       line_start;
   logic       frame_start;

   modport master (input ce, output hpos, vpos, hsync, vsync, display_on, line_start, frame_start);
   modport slave  (output ce, input hpos, vpos, hsync, vsync, display_on, line_start, frame_start);
endinterface

// File: rtl/vga_axis_counter.sv
// One timing axis: position counter plus ACTIVE->FP->SYNC->BP phase FSM with a length counter.
// "phase" reports the phase being entered on this edge so the top can register its decode.
module vga_axis_counter
   import vga_timing_pkg::*;
#(
   parameter int unsigned ACTIVE = DEF_H_ACTIVE,
   parameter int unsigned FP     = DEF_H_FP,
   parameter int unsigned SYNC   = DEF_H_SYNC,
   parameter int unsigned BP     = DEF_H_BP
)(
   input  logic       clk,
   input  logic       rst,
   input  logic       step,
   output logic [9:0] pos,
   output phase_t     phase,
   output logic       wrap
);
   localparam int unsigned TOTAL       = axis_total(ACTIVE, FP, SYNC, BP);
   localparam logic [9:0]  POS_LAST    = 10'(TOTAL - 1);
   localparam logic [9:0]  ACTIVE_LAST = 10'(ACTIVE - 1);
   localparam logic [9:0]  FP_LAST     = 10'(FP - 1);
   localparam logic [9:0]  SYNC_LAST   = 10'(SYNC - 1);
   localparam logic [9:0]  BP_LAST     = 10'(BP - 1);

   if (ACTIVE == 0 || FP == 0 || SYNC == 0 || BP == 0) begin : g_zero_phase
      $error("vga_axis_counter: zero-length phase parameter");
   end
   if (TOTAL > 1024) begin : g_total_range
      $error("vga_axis_counter: axis total exceeds 10-bit counter range");
   end

   phase_t     phase_r, phase_s;
   logic [9:0] len_r, len_s, pos_s;
   logic       term_s;

   // Terminal-count detect for the phase currently running
   always_comb begin
      term_s = 1'b0;
      case (phase_r)
         PH_ACTIVE: term_s = (len_r == ACTIVE_LAST);
         PH_FP:     term_s = (len_r == FP_LAST);
         PH_SYNC:   term_s = (len_r == SYNC_LAST);
         PH_BP:     term_s = (len_r == BP_LAST);
         default:   term_s = 1'b0;
      endcase
   end

   // Next position, length count and phase
   always_comb begin
      phase_s = phase_r;
      len_s   = len_r;
      pos_s   = pos;
      if (step) begin
         pos_s = (pos == POS_LAST) ? 10'd0 : pos + 10'd1;
         if (term_s) begin
            len_s = 10'd0;
            case (phase_r)
               PH_ACTIVE: phase_s = PH_FP;
               PH_FP:     phase_s = PH_SYNC;
               PH_SYNC:   phase_s = PH_BP;
               PH_BP:     phase_s = PH_ACTIVE;
               default:   phase_s = PH_ACTIVE;
            endcase
         end else begin
            len_s = len_r + 10'd1;
         end
      end else begin
         pos_s = pos;
      end
   end

   // Reset parks the axis on the last back-porch count so the first step enters position 0
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pos     <= POS_LAST;
         phase_r <= PH_BP;
         len_r   <= BP_LAST;
      end else begin
         pos     <= pos_s;
         phase_r <= phase_s;
         len_r   <= len_s;
      end
   end

   assign phase = phase_s;
   assign wrap  = step && (pos == POS_LAST);

endmodule

// File: rtl/vga_sync_gen.sv
// VGA timing generator: two axis counters plus registered sync, blanking and start-pulse decode.
module vga_sync_gen
   import vga_timing_pkg::*;
#(
   parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
   parameter int unsigned H_FP     = DEF_H_FP,
   parameter int unsigned H_SYNC   = DEF_H_SYNC,
   parameter int unsigned H_BP     = DEF_H_BP,
   parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
   parameter int unsigned V_FP     = DEF_V_FP,
   parameter int unsigned V_SYNC   = DEF_V_SYNC,
   parameter int unsigned V_BP     = DEF_V_BP,
   parameter logic        SYNC_POL = DEF_SYNC_POL
)(
   input  logic           clk,
   input  logic           rst,
   vga_sync_gen_if.master bus
);
   logic [9:0] h_pos, v_pos;
   phase_t     h_phase, v_phase;
   logic       h_wrap, v_wrap;
   logic       hsync_r, vsync_r, display_on_r, line_start_r, frame_start_r;

   vga_axis_counter #(.ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP)) u_h_axis (
      .clk   (clk),
      .rst   (rst),
      .step  (bus.ce),
      .pos   (h_pos),
      .phase (h_phase),
      .wrap  (h_wrap)
   );

   vga_axis_counter #(.ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP)) u_v_axis (
      .clk   (clk),
      .rst   (rst),
      .step  (h_wrap),
      .pos   (v_pos),
      .phase (v_phase),
      .wrap  (v_wrap)
   );

   // Decode the phases being entered so outputs line up with the new coordinates
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hsync_r       <= ~SYNC_POL;
         vsync_r       <= ~SYNC_POL;
         display_on_r  <= 1'b0;
         line_start_r  <= 1'b0;
         frame_start_r <= 1'b0;
      end else if (bus.ce) begin
         hsync_r       <= (h_phase == PH_SYNC) ? SYNC_POL : ~SYNC_POL;
         vsync_r       <= (v_phase == PH_SYNC) ? SYNC_POL : ~SYNC_POL;
         display_on_r  <= (h_phase == PH_ACTIVE) && (v_phase == PH_ACTIVE);
         line_start_r  <= h_wrap;
         frame_start_r <= h_wrap && v_wrap;
      end else begin
         line_start_r  <= 1'b0;
         frame_start_r <= 1'b0;
      end
   end

   assign bus.hpos        = h_pos;
   assign bus.vpos        = v_pos;
   assign bus.hsync       = hsync_r;
   assign bus.vsync       = vsync_r;
   assign bus.display_on  = display_on_r;
   assign bus.line_start  = line_start_r;
   assign bus.frame_start = frame_start_r;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Scoreboard bench: default 640x480 instance plus a tiny-timing, active-high-sync instance
// so frame wraps are reached quickly; expectations come from a position-arithmetic model.
module tb_vga_sync_gen;

   typedef struct packed {
      logic [9:0] hpos;
      logic [9:0] vpos;
      logic       hsync;
      logic       vsync;
      logic       display_on;
      logic       line_start;
      logic       frame_start;
   } exp_t;

   logic clk    = 1'b0;
   logic rst    = 1'b0;
   logic ce     = 1'b0;
   bit   mon_en = 1'b0;
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   vga_sync_gen_if vif_a();
   vga_sync_gen_if vif_b();
   assign vif_a.ce = ce;
   assign vif_b.ce = ce;

   vga_sync_gen u_dut_a (.clk(clk), .rst(rst), .bus(vif_a));

   vga_sync_gen #(
      .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
      .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(2),
      .SYNC_POL(1'b1)
   ) u_dut_b (.clk(clk), .rst(rst), .bus(vif_b));

   int p_ha[2] = '{640, 8};
   int p_hf[2] = '{16, 2};
   int p_hs[2] = '{96, 3};
   int p_hb[2] = '{48, 2};
   int p_va[2] = '{480, 6};
   int p_vf[2] = '{10, 1};
   int p_vs[2] = '{2, 2};
   int p_vb[2] = '{33, 2};
   bit p_pol[2] = '{1'b0, 1'b1};

   int   mh[2];
   int   mv[2];
   exp_t mo[2];
   exp_t q_a[$];
   exp_t q_b[$];

   // Reference: advance screen position by one pixel and derive every output from it
   function automatic void model_edge(input int d, input bit r, input bit c);
      int ht, vt, hs0, vs0;
      ht  = p_ha[d] + p_hf[d] + p_hs[d] + p_hb[d];
      vt  = p_va[d] + p_vf[d] + p_vs[d] + p_vb[d];
      hs0 = p_ha[d] + p_hf[d];
      vs0 = p_va[d] + p_vf[d];
      if (r) begin
         mh[d] = ht - 1;
         mv[d] = vt - 1;
         mo[d].hsync       = ~p_pol[d];
         mo[d].vsync       = ~p_pol[d];
         mo[d].display_on  = 1'b0;
         mo[d].line_start  = 1'b0;
         mo[d].frame_start = 1'b0;
      end else if (c) begin
         mh[d] = (mh[d] + 1) % ht;
         if (mh[d] == 0) mv[d] = (mv[d] + 1) % vt;
         mo[d].line_start  = (mh[d] == 0);
         mo[d].frame_start = (mh[d] == 0) && (mv[d] == 0);
         mo[d].hsync       = (mh[d] >= hs0 && mh[d] < hs0 + p_hs[d]) ? p_pol[d] : ~p_pol[d];
         mo[d].vsync       = (mv[d] >= vs0 && mv[d] < vs0 + p_vs[d]) ? p_pol[d] : ~p_pol[d];
         mo[d].display_on  = (mh[d] < p_ha[d]) && (mv[d] < p_va[d]);
      end else begin
         mo[d].line_start  = 1'b0;
         mo[d].frame_start = 1'b0;
      end
      mo[d].hpos = 10'(mh[d]);
      mo[d].vpos = 10'(mv[d]);
   endfunction

   function automatic void push_expected(input bit r, input bit c);
      model_edge(0, r, c);
      model_edge(1, r, c);
      q_a.push_back(mo[0]);
      q_b.push_back(mo[1]);
   endfunction

   function automatic void check_one(input int d, input exp_t act);
      exp_t e;
      checks++;
      if ((d == 0 && q_a.size() == 0) || (d == 1 && q_b.size() == 0)) begin
         errors++;
         $display("FAIL sb_underflow dut%0d t=%0t: output presented with no expected entry", d, $time);
         return;
      end
      if (d == 0) e = q_a.pop_front();
      else        e = q_b.pop_front();
      if (act !== e) begin
         errors++;
         $display("FAIL timing_dut%0d t=%0t actual h=%0d v=%0d hs=%b vs=%b de=%b ls=%b fs=%b required h=%0d v=%0d hs=%b vs=%b de=%b ls=%b fs=%b",
                  d, $time, act.hpos, act.vpos, act.hsync, act.vsync, act.display_on, act.line_start,
                  act.frame_start, e.hpos, e.vpos, e.hsync, e.vsync, e.display_on, e.line_start,
                  e.frame_start);
      end
   endfunction

   // Monitor: outputs change on clk edges and on asynchronous reset assertion
   initial begin
      exp_t act;
      forever begin
         @(posedge clk or posedge rst);
         #1;
         if (mon_en) begin
            act = {vif_a.hpos, vif_a.vpos, vif_a.hsync, vif_a.vsync, vif_a.display_on,
                   vif_a.line_start, vif_a.frame_start};
            check_one(0, act);
            act = {vif_b.hpos, vif_b.vpos, vif_b.hsync, vif_b.vsync, vif_b.display_on,
                   vif_b.line_start, vif_b.frame_start};
            check_one(1, act);
         end
      end
   end

   task automatic cycle(input bit r, input bit c);
      @(negedge clk);
      mon_en = 1'b1;
      if (r && !rst) push_expected(1'b1, c);
      push_expected(r, c);
      rst = r;
      ce  = c;
   endtask

   initial begin
      repeat (3) cycle(1'b1, 1'b0);
      repeat (1700) cycle(1'b0, 1'b1);
      for (int i = 0; i < 400; i++) cycle(1'b0, (i % 2) == 0);
      cycle(1'b1, 1'b1);
      cycle(1'b1, 1'b0);
      repeat (200) cycle(1'b0, 1'b1);
      for (int i = 0; i < 3000; i++) begin
         cycle($urandom_range(0, 299) == 0, $urandom_range(0, 3) != 0);
      end
      cycle(1'b0, 1'b1);
      @(posedge clk);
      #2;
      checks++;
      if (q_a.size() + q_b.size() != 0) begin
         errors++;
         $display("FAIL sb_drain actual=%0d pending required=0", q_a.size() + q_b.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
